// File: rtl/sipo_br.sv
// Serial-in, parallel-out receiver for the start-strobed, MSB-first PISO link.
// Samples one bit every DIV clocks on the last cycle of each bit period.
module sipo_br #(
  parameter int WIDTH = 8,
  parameter int DIV   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sin,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             busy
);

  localparam int PW = $clog2(DIV + 1);
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [PW-1:0] PHASE_ONE  = PW'(1);
  localparam logic [PW-1:0] PHASE_LAST = PW'(DIV);
  localparam logic [BW-1:0] BIT_TOP    = BW'(WIDTH - 1);
  localparam logic [BW-1:0] BIT_ZERO   = '0;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state_q,  state_d;
  logic [PW-1:0]    phase_q,  phase_d;
  logic [BW-1:0]    bitidx_q, bitidx_d;
  logic [WIDTH-1:0] shreg_q,  shreg_d;
  logic [WIDTH-1:0] dout_q,   dout_d;
  logic             valid_q,  valid_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      phase_q  <= PHASE_ONE;
      bitidx_q <= BIT_TOP;
      shreg_q  <= '0;
      dout_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      bitidx_q <= bitidx_d;
      shreg_q  <= shreg_d;
      dout_q   <= dout_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    bitidx_d = bitidx_q;
    shreg_d  = shreg_q;
    dout_d   = dout_q;
    valid_d  = 1'b0;
    busy     = (state_q == SHIFT);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = SHIFT;
          phase_d  = PHASE_ONE;
          bitidx_d = BIT_TOP;
          shreg_d  = '0;
        end
      end
      SHIFT: begin
        // start is deliberately ignored here so a frame in flight is never disturbed
        if (phase_q == PHASE_LAST) begin
          shreg_d = {shreg_q[WIDTH-2:0], sin};
          phase_d = PHASE_ONE;
          if (bitidx_q == BIT_ZERO) begin
            dout_d   = {shreg_q[WIDTH-2:0], sin};
            valid_d  = 1'b1;
            bitidx_d = BIT_TOP;
            state_d  = IDLE;
          end else begin
            bitidx_d = bitidx_q - BW'(1);
          end
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dout  = dout_q;
  assign valid = valid_q;

endmodule

// File: doc/sipo_br.md
# sipo_br

Serial-in, parallel-out receiver with a bit-rate divider. It is the receive end of the start-strobed, MSB-first serial link driven by our PISO bit-rate transmitters. After a `start` strobe it samples `WIDTH` serial bits, one every `DIV` clocks, and presents the assembled word on `dout` with a one-cycle `valid` pulse. It sits next to the transmitter in loopback benches and at the parallel side of any serial-to-bus bridge.

## Interface
- `WIDTH`, default 8: frame length in bits (>= 2).
- `DIV`, default 2: clocks per serial bit (>= 1). Matches the transmitter's per-bit hold time.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  frame-start strobe, same timing as the transmitter's `start`.
- `sin`  input  1  serial data, MSB first.
- `dout`  output  WIDTH  last completed word; holds its value between frames.
- `valid`  output  1  high for exactly one cycle when `dout` is updated.
- `busy`  output  1  high while a frame is being received.

## Operation
- Two states: IDLE and SHIFT.
- Registers:
  - `phase`: counts 1..DIV; width $clog2(DIV+1).
  - `bitidx`: counts WIDTH-1 down to 0.
  - `shreg`: WIDTH-bit internal shift register.
  - `dout`, `valid`.
- IDLE:
  - `busy`=0.
  - `start`=1 at an edge -> SHIFT, `phase`<=1, `bitidx`<=WIDTH-1, `shreg`<=0.
  - `start`=0 -> stay in IDLE.
  - `sin` is ignored. It may be X while idle, because the transmitter drives X when idle.
- SHIFT:
  - `busy`=1.
  - Each edge with `phase`<DIV: `phase`<=`phase`+1.
  - Edge with `phase`==DIV (last cycle of the bit period): sample `sin` into `shreg` (shift left, sample enters bit 0), then `phase`<=1 and `bitidx`<=`bitidx`-1.
  - Sample edge with `bitidx`==0: `dout`<={shreg[WIDTH-2:0], sin}, `valid`<=1, state<=IDLE.
- `valid` deasserts on the next edge unconditionally.
- `start` during SHIFT is ignored; the frame in progress continues unaffected.
- `dout` changes only at frame completion; partial frames never appear on it.
- DIV==1: every SHIFT edge is a sample edge, and `phase` stays at 1.
- Reset (asserted at any time, including mid-frame):
  - Immediately: state=IDLE, `phase`=1, `bitidx`=WIDTH-1, `shreg`=0, `dout`=0, `valid`=0, `busy`=0.
  - Any partial frame is discarded, with no `valid` pulse.
- Deassertion of `rst_n` is assumed synchronous to `clk` by the system reset synchronizer.

## Timing
- Let E0 be the edge at which `start` is sampled high in IDLE.
- Bit k (k = WIDTH-1 .. 0) is sampled at edge E0 + (WIDTH-k)*DIV.
  - WIDTH=8, DIV=2: samples at E0+2, +4, ..., +16.
- `dout` updates and `valid` rises at edge E0 + WIDTH*DIV. `valid` falls at E0 + WIDTH*DIV + 1.
- `busy` is high from E0 to E0 + WIDTH*DIV; it is low in the `valid` cycle.
- Earliest next accepted `start` is at edge E0 + WIDTH*DIV + 1. This matches the transmitter's minimum one-cycle idle gap, so back-to-back frames are received with no loss.
- Sampling on the last cycle of each bit period gives the transmitter DIV-1 cycles of settling margin.
- Throughput: one word per WIDTH*DIV + 1 cycles.

## Test plan
- Reset: hold `rst_n`=0 with random `start`/`sin` -> `dout`=0, `valid`=0, `busy`=0. Release, then idle 10 cycles -> no `valid`.
- Single frame, WIDTH=8, DIV=2: `start` at E0, drive 0xA5 MSB first with 2 cycles per bit -> `dout`=0xA5 and `valid`=1 for exactly the cycle after E0+16. `busy` high E0..E0+16. `sin`=X while idle causes no X on `dout`.
- Loopback with the transmitter (shared `clk`/`start`): frames 0x3C, 0xFF, 0x00, 0x81 back-to-back with minimum gap -> four `valid` pulses with matching `dout` in order.
- Ignored `start`: pulse `start` at E0+5 during a 0x5A frame -> single `valid` at E0+16 with `dout`=0x5A, and no second frame starts.
- Reset mid-frame: receive 0xF0 with `dout`=0x12 from a prior frame, pulse `rst_n` low at E0+7 -> `dout`=0 and no `valid`. A following frame 0x6E is received correctly.
- Parameter sweep: DIV=1 and DIV=5 with WIDTH=8, frame 0x81 -> `valid` at E0+8 and E0+40 respectively, `dout`=0x81.
